cdc_sync_filter: RTL and testbench

Multi-channel synchronizer with a per-channel stability filter and optional edge-pulse outputs. It brings WIDTH asynchronous level signals (switches, external status pins, slow cross-domain flags) into the clk domain through a PIPELINE-deep synchronizer. It then suppresses glitches: an output changes only after the synchronized input has held the new level for FILTER consecutive clocks. It sits at the board-I/O boundary, ahead of any logic that consumes external levels.

---
 rtl/cdc_pkg.sv | 14 +
 rtl/cdc_sync_filter_chan.sv | 67 ++++++
 rtl/cdc_sync_filter.sv | 44 ++++
 tb/tb_cdc_sync_filter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared helpers for the CDC blocks: counter sizing and parameter-range messages.
package cdc_pkg;

  function automatic int unsigned cdc_cnt_width(input int unsigned filter);
    int unsigned w;
    w = $clog2(filter);
    return (w < 1) ? 1 : w;
  endfunction

  localparam string CDC_MSG_WIDTH    = "cdc: WIDTH must be >= 1";
  localparam string CDC_MSG_PIPELINE = "cdc: PIPELINE must be >= 2";
  localparam string CDC_MSG_FILTER   = "cdc: FILTER must be >= 1";

endpackage

// File: rtl/cdc_sync_filter_chan.sv
// One channel: PIPELINE-deep synchronizer, stability counter, filtered level and edge pulses.
// Edge pulses are only generated when CDC_SYNC_FILTER_EDGE_EN is defined.
module cdc_sync_filter_chan
  import cdc_pkg::*;
#(
  parameter int unsigned PIPELINE    = 2,
  parameter int unsigned FILTER      = 4,
  parameter logic        RESET_STATE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int unsigned          CNT_W  = cdc_cnt_width(FILTER);
  localparam logic [CNT_W-1:0]     CNT_TC = CNT_W'(FILTER - 1);

  (* syn_preserve = 1 *) logic [PIPELINE-1:0] meta;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             update;

  assign s      = meta[PIPELINE-1];
  assign update = (s != q) && (cnt == CNT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {PIPELINE{RESET_STATE}};
    end else begin
      meta <= {meta[PIPELINE-2:0], d};
    end
  end

  // A mismatch that clears early restarts the count, so separate glitches never add up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RESET_STATE;
      cnt <= '0;
    end else if (update) begin
      q   <= s;
      cnt <= '0;
    end else if (s == q) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef CDC_SYNC_FILTER_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= update & s;
      fall <= update & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/cdc_sync_filter.sv
// Multi-channel synchronizer with per-channel glitch filter and optional edge pulses.
// Optional feature macro: CDC_SYNC_FILTER_EDGE_EN (evaluated in cdc_sync_filter_chan).
module cdc_sync_filter
  import cdc_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      PIPELINE    = 2,
  parameter logic [WIDTH-1:0] RESET_STATE = '0,
  parameter int unsigned      FILTER      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 1) begin : g_bad_width
    $error("%s", CDC_MSG_WIDTH);
  end
  if (PIPELINE < 2) begin : g_bad_pipeline
    $error("%s", CDC_MSG_PIPELINE);
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("%s", CDC_MSG_FILTER);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    cdc_sync_filter_chan #(
      .PIPELINE    (PIPELINE),
      .FILTER      (FILTER),
      .RESET_STATE (RESET_STATE[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d[i]),
      .q     (q[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: four instances covering reset, clean edges,
// glitch rejection, mid-count reset and walking-one channel independence.
module tb_cdc_sync_filter;

`ifdef CDC_SYNC_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // u0: WIDTH=4, RESET_STATE=1010
  logic       rst0 = 1'b0;
  logic [3:0] d0 = '0, q0, rise0, fall0;
  // u1: defaults
  logic       rst1 = 1'b0;
  logic [0:0] d1 = '0, q1, rise1, fall1;
  // u2: FILTER=8
  logic       rst2 = 1'b0;
  logic [0:0] d2 = '0, q2, rise2, fall2;
  // u3: WIDTH=8, PIPELINE=3, FILTER=1
  logic       rst3 = 1'b0;
  logic [7:0] d3 = '0, q3, rise3, fall3;

  cdc_sync_filter #(.WIDTH(4), .RESET_STATE(4'b1010)) u0 (
    .clk(clk), .rst_n(rst0), .d(d0), .q(q0), .rise(rise0), .fall(fall0));
  cdc_sync_filter u1 (
    .clk(clk), .rst_n(rst1), .d(d1), .q(q1), .rise(rise1), .fall(fall1));
  cdc_sync_filter #(.WIDTH(1), .FILTER(8)) u2 (
    .clk(clk), .rst_n(rst2), .d(d2), .q(q2), .rise(rise2), .fall(fall2));
  cdc_sync_filter #(.WIDTH(8), .PIPELINE(3), .FILTER(1)) u3 (
    .clk(clk), .rst_n(rst3), .d(d3), .q(q3), .rise(rise3), .fall(fall3));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] prev;

    // Reset hold with random inputs
    for (int i = 0; i < 8; i++) begin
      d0 = 4'($urandom);
      tick(1);
      check("rst_q",    8'(q0),    8'h0a);
      check("rst_rise", 8'(rise0), 8'h00);
      check("rst_fall", 8'(fall0), 8'h00);
    end
    d0 = 4'b1010;
    rst0 = 1'b1;
    tick(10);
    check("rst_rel_q", 8'(q0), 8'h0a);

    // Clean rising then falling edge, defaults
    rst1 = 1'b1;
    tick(4);
    d1 = 1'b1;
    tick(5);
    check("clean_q_e5",    8'(q1), 8'h00);
    tick(1);
    check("clean_q_e6",    8'(q1),    8'h01);
    check("clean_rise_e6", 8'(rise1), 8'(EDGE_EN));
    check("clean_fall_e6", 8'(fall1), 8'h00);
    tick(1);
    check("clean_rise_e7", 8'(rise1), 8'h00);
    d1 = 1'b0;
    tick(5);
    check("fall_q_e5",    8'(q1), 8'h01);
    tick(1);
    check("fall_q_e6",    8'(q1),    8'h00);
    check("fall_fall_e6", 8'(fall1), 8'(EDGE_EN));
    check("fall_rise_e6", 8'(rise1), 8'h00);
    tick(1);
    check("fall_fall_e7", 8'(fall1), 8'h00);

    // Glitch rejection: 3 high, 2 low, 3 high, then low
    tick(4);
    d1 = 1'b1; tick(3);
    d1 = 1'b0; tick(2);
    d1 = 1'b1; tick(3);
    d1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("glitch_q",    8'(q1),    8'h00);
      check("glitch_rise", 8'(rise1), 8'h00);
      check("glitch_fall", 8'(fall1), 8'h00);
      tick(1);
    end
    // 5-clock pulse is accepted at edge 6
    d1 = 1'b1;
    tick(5);
    d1 = 1'b0;
    check("long_q_e5",    8'(q1), 8'h00);
    tick(1);
    check("long_q_e6",    8'(q1),    8'h01);
    check("long_rise_e6", 8'(rise1), 8'(EDGE_EN));
    tick(10);
    check("long_q_back", 8'(q1), 8'h00);

    // Mid-count reset, FILTER=8
    rst2 = 1'b1;
    tick(4);
    d2 = 1'b1;
    tick(5);
    rst2 = 1'b0;
    #1;
    check("mid_q",    8'(q2),    8'h00);
    check("mid_rise", 8'(rise2), 8'h00);
    check("mid_fall", 8'(fall2), 8'h00);
    tick(3);
    check("mid_hold_q", 8'(q2), 8'h00);
    rst2 = 1'b1;
    tick(9);
    check("rel_q_e9", 8'(q2), 8'h00);
    tick(1);
    check("rel_q_e10",    8'(q2),    8'h01);
    check("rel_rise_e10", 8'(rise2), 8'(EDGE_EN));
    tick(1);
    check("rel_rise_e11", 8'(rise2), 8'h00);
    check("rel_q_e11",    8'(q2),    8'h01);

    // Walking one, WIDTH=8 PIPELINE=3 FILTER=1
    rst3 = 1'b1;
    tick(5);
    prev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      d3 = 8'h01 << i;
      tick(3);
      check("walk_q_e3", q3, prev);
      tick(1);
      check("walk_q_e4",    q3,    8'h01 << i);
      check("walk_rise_e4", rise3, EDGE_EN ? (8'h01 << i) : 8'h00);
      check("walk_fall_e4", fall3, EDGE_EN ? prev : 8'h00);
      prev = 8'h01 << i;
    end
    d3 = 8'h00;
    tick(4);
    check("walk_end_q",    q3,    8'h00);
    check("walk_end_fall", fall3, EDGE_EN ? 8'h80 : 8'h00);
    check("walk_end_rise", rise3, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
